// File: rtl/vx_sfu_commit_arb.sv
// vx_sfu_commit_arb
// Merges the commit streams of the SFU sub-units (CSR, warp control, ...)
// into the single SFU commit port that feeds the commit stage.
// Round-robin arbitration per packet: once an input's sop beat is granted,
// that input owns the output until its eop beat is granted. A 2-entry
// elastic buffer gives 1-cycle latency, full throughput and registered outputs.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   in_valid/in_ready        per-input beat handshake
//   in_data                  per-input payload, input i at [i*DATAW +: DATAW]
//   in_sop/in_eop            packet delimiters per input
//   out_valid/out_ready      merged beat handshake
//   out_data/out_sop/out_eop merged beat payload and delimiters
//   out_sel                  source input index of the current out beat
//
// Optional macro VX_SFU_COMMIT_ARB_PERF_EN adds two saturating 44-bit
// counters: perf_stall_cycles and perf_lock_cycles.

module vx_sfu_commit_arb #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned DATAW      = 64,
  localparam int unsigned SELW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  output logic [NUM_INPUTS-1:0]       in_ready,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]       in_sop,
  input  logic [NUM_INPUTS-1:0]       in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATAW-1:0]            out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [SELW-1:0]             out_sel
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
  ,
  output logic [43:0]                 perf_stall_cycles,
  output logic [43:0]                 perf_lock_cycles
`endif
);

  // Buffered beat layout: {sel, sop, eop, data}
  localparam int unsigned BEATW = SELW + 2 + DATAW;
  localparam int unsigned PERFW = 44;

  // Arbitration state
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] locked_idx;
  logic            lock;

  // Grant signals
  logic [NUM_INPUTS-1:0] grant;
  logic [SELW-1:0]       grant_idx;
  logic                  grant_any;
  int unsigned           cand;

  // Transfer signals
  logic             buf_ready;
  logic             xfer;
  logic             xfer_sop;
  logic             xfer_eop;
  logic [DATAW-1:0] xfer_data;
  logic [SELW-1:0]  next_ptr;

  // Elastic buffer state
  logic [1:0]       count_q, count_n;
  logic [BEATW-1:0] head_q, head_n;
  logic [BEATW-1:0] skid_q, skid_n;
  logic [BEATW-1:0] beat_in;
  logic             deq;

  // Grant: locked input only, otherwise first valid input from rr_ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    if (lock) begin
      if (in_valid[locked_idx]) begin
        grant[locked_idx] = 1'b1;
        grant_idx         = locked_idx;
        grant_any         = 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
        cand = 32'(rr_ptr) + k;
        if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
        if (!grant_any && in_valid[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = SELW'(cand);
          grant_any   = 1'b1;
        end
      end
    end
  end

  assign buf_ready = (count_q != 2'd2);

  // in_ready depends only on buffer occupancy and grant, never on out_ready
  assign in_ready  = {NUM_INPUTS{buf_ready & ~reset}} & grant;
  assign xfer      = grant_any & buf_ready & ~reset;
  assign xfer_sop  = in_sop[grant_idx];
  assign xfer_eop  = in_eop[grant_idx];
  assign xfer_data = in_data[32'(grant_idx)*DATAW +: DATAW];
  assign next_ptr  = (grant_idx == SELW'(NUM_INPUTS - 1)) ? '0 : grant_idx + SELW'(1);
  assign beat_in   = {grant_idx, xfer_sop, xfer_eop, xfer_data};

  // Lock and round-robin pointer; a single-beat packet never sets lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock       <= 1'b0;
      locked_idx <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      if (!xfer_eop) begin
        lock       <= 1'b1;
        locked_idx <= grant_idx;
      end else begin
        lock   <= 1'b0;
        rr_ptr <= next_ptr;
      end
    end
  end

  assign deq = out_valid & out_ready;

  // Elastic buffer next state: head drives the outputs, skid holds the second entry
  always_comb begin
    head_n  = head_q;
    skid_n  = skid_q;
    count_n = count_q;
    case (count_q)
      2'd0: begin
        if (xfer) begin
          head_n  = beat_in;
          count_n = 2'd1;
        end
      end
      2'd1: begin
        if (xfer && deq) begin
          head_n = beat_in;
        end else if (xfer) begin
          skid_n  = beat_in;
          count_n = 2'd2;
        end else if (deq) begin
          count_n = 2'd0;
        end
      end
      default: begin
        if (deq) begin
          head_n = skid_q;
          if (xfer) begin
            skid_n = beat_in;
          end else begin
            count_n = 2'd1;
          end
        end
      end
    endcase
  end

  // Elastic buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      count_q   <= count_n;
      head_q    <= head_n;
      skid_q    <= skid_n;
      out_valid <= (count_n != 2'd0);
    end
  end

  assign out_sel  = head_q[BEATW-1 -: SELW];
  assign out_sop  = head_q[DATAW+1];
  assign out_eop  = head_q[DATAW];
  assign out_data = head_q[DATAW-1:0];

`ifdef VX_SFU_COMMIT_ARB_PERF_EN
  logic [NUM_INPUTS-1:0] other_valid;
  logic                  stall_evt;
  logic                  lock_evt;

  always_comb begin
    other_valid             = in_valid;
    other_valid[locked_idx] = 1'b0;
  end

  assign stall_evt = (|in_valid) & ~buf_ready;
  assign lock_evt  = lock & (|other_valid);

  // Saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_lock_cycles  <= '0;
    end else begin
      if (stall_evt && (perf_stall_cycles != {PERFW{1'b1}}))
        perf_stall_cycles <= perf_stall_cycles + PERFW'(1);
      if (lock_evt && (perf_lock_cycles != {PERFW{1'b1}}))
        perf_lock_cycles <= perf_lock_cycles + PERFW'(1);
    end
  end
`endif

`ifndef SYNTHESIS
  // Malformed stream: sop must start a packet exactly when unlocked
  always_ff @(posedge clk) begin
    if (!reset && xfer) begin
      assert (xfer_sop == ~lock);
    end
  end
`endif

endmodule

// File: tb/tb_vx_sfu_commit_arb.sv
// Self-checking bench for vx_sfu_commit_arb (NUM_INPUTS=2, DATAW=64).
// Accepted beats are pushed to a scoreboard queue and popped when they
// leave the output port; directed checks cover arbitration, locking,
// backpressure, locked-input stalls and reset mid-packet.

module tb_vx_sfu_commit_arb;

  localparam int N = 2;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_sop;
  logic [N-1:0]     in_eop;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_sop;
  logic             out_eop;
  logic [0:0]       out_sel;
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
  logic [43:0]      perf_stall_cycles;
  logic [43:0]      perf_lock_cycles;
`endif

  vx_sfu_commit_arb #(.NUM_INPUTS(N), .DATAW(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_sel  (out_sel)
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_lock_cycles (perf_lock_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0]   sel;
    logic         sop;
    logic         eop;
    logic [W-1:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t exp_beat;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int i, input logic v, input logic s, input logic e,
                        input logic [W-1:0] d);
    in_valid[i]        = v;
    in_sop[i]          = s;
    in_eop[i]          = e;
    in_data[i*W +: W]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pop on output handshake first, then push accepted beats
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(1), 64'(0));
        end else begin
          exp_beat = sb.pop_front();
          chk("sb_data", out_data, exp_beat.data);
          chk("sb_sel", 64'(out_sel), 64'(exp_beat.sel));
          chk("sb_sop", 64'(out_sop), 64'(exp_beat.sop));
          chk("sb_eop", 64'(out_eop), 64'(exp_beat.eop));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i])
          sb.push_back('{sel: 1'(i), sop: in_sop[i], eop: in_eop[i], data: in_data[i*W +: W]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d0, d1, last, cd;
    logic         g0;
    int           acc;
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
    logic [43:0]  perf_snap;
`endif

    reset     = 1'b1;
    in_valid  = '0;
    in_sop    = '0;
    in_eop    = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset: nothing accepted or presented, even with inputs valid
    #1;
    set_in(0, 1'b1, 1'b1, 1'b1, 64'h11);
    set_in(1, 1'b1, 1'b1, 1'b1, 64'h22);
    repeat (3) begin
      step();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
    end
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_out_sel", 64'(out_sel), 64'(0));
    in_valid = '0;
    step();
    reset = 1'b0;
    step();
    chk("idle_in_ready", 64'(in_ready), 64'(0));
    chk("idle_out_valid", 64'(out_valid), 64'(0));

    // Single-beat packets from both inputs alternate, 1-cycle latency
    d0 = 64'h1000;
    d1 = 64'h2000;
    for (int c = 0; c < 8; c++) begin
      set_in(0, 1'b1, 1'b1, 1'b1, d0);
      set_in(1, 1'b1, 1'b1, 1'b1, d1);
      #1;
      chk("rr_grant", 64'(in_ready), (c % 2 == 0) ? 64'(1) : 64'(2));
      g0   = in_ready[0];
      last = g0 ? d0 : d1;
      step();
      chk("rr_out_valid", 64'(out_valid), 64'(1));
      chk("rr_out_data", out_data, last);
      chk("rr_out_sel", 64'(out_sel), 64'(c % 2));
      if (g0) d0 = d0 + 64'(1);
      else    d1 = d1 + 64'(1);
    end
    in_valid = '0;
    step();
    step();
    chk("rr_drained", 64'(out_valid), 64'(0));

    // Packet lock: input1 waits until input0's eop beat transfers
    set_in(0, 1'b1, 1'b1, 1'b0, 64'hA0);
    #1;
    chk("lock_grant0", 64'(in_ready), 64'(1));
    step();
    chk("lock_out0", out_data, 64'hA0);
    set_in(0, 1'b1, 1'b0, 1'b0, 64'hA1);
    set_in(1, 1'b1, 1'b1, 1'b1, 64'hB0);
    #1;
    chk("lock_grant1", 64'(in_ready), 64'(1));
    step();
    chk("lock_out1", out_data, 64'hA1);
    set_in(0, 1'b1, 1'b0, 1'b1, 64'hA2);
    #1;
    chk("lock_grant2", 64'(in_ready), 64'(1));
    step();
    chk("lock_out2", out_data, 64'hA2);
    set_in(0, 1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    chk("lock_grant3", 64'(in_ready), 64'(2));
    step();
    chk("lock_out3", out_data, 64'hB0);
    chk("lock_out3_sel", 64'(out_sel), 64'(1));
    set_in(1, 1'b0, 1'b0, 1'b0, 64'h0);
    step();
    chk("lock_idle", 64'(out_valid), 64'(0));

    // Backpressure: two beats fill the buffer, then input0 is held off
    out_ready = 1'b0;
    cd  = 64'hC0;
    acc = 0;
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
    perf_snap = perf_stall_cycles;
`endif
    for (int c = 0; c < 5; c++) begin
      set_in(0, 1'b1, 1'b1, 1'b1, cd);
      #1;
      chk("bp_in_ready", 64'(in_ready[0]), (c < 2) ? 64'(1) : 64'(0));
      g0 = in_ready[0];
      if (g0) acc++;
      step();
      if (g0) cd = cd + 64'(1);
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_hold", out_data, 64'hC0);
    end
    chk("bp_accepted", 64'(acc), 64'(2));
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
    chk("bp_perf_stall", 64'(perf_stall_cycles - perf_snap), 64'(3));
`endif
    set_in(0, 1'b0, 1'b0, 1'b0, 64'h0);
    out_ready = 1'b1;
    step();
    chk("bp_drain1", out_data, 64'hC1);
    chk("bp_drain1_valid", 64'(out_valid), 64'(1));
    step();
    chk("bp_drain_done", 64'(out_valid), 64'(0));

    // Locked input stalls mid-packet: input1 stays blocked, output idles
    set_in(0, 1'b1, 1'b1, 1'b0, 64'hD0);
    #1;
    chk("stall_start", 64'(in_ready), 64'(1));
    step();
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
    perf_snap = perf_lock_cycles;
`endif
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1'b0, 1'b0, 1'b0, 64'h0);
      set_in(1, 1'b1, 1'b1, 1'b1, 64'hE0);
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      step();
      chk("stall_out_valid", 64'(out_valid), 64'(0));
    end
`ifdef VX_SFU_COMMIT_ARB_PERF_EN
    chk("stall_perf_lock", 64'(perf_lock_cycles - perf_snap), 64'(4));
`endif
    set_in(0, 1'b1, 1'b0, 1'b1, 64'hD1);
    #1;
    chk("stall_resume", 64'(in_ready), 64'(1));
    step();
    chk("stall_out_d1", out_data, 64'hD1);
    set_in(0, 1'b0, 1'b0, 1'b0, 64'h0);
    #1;
    chk("stall_release", 64'(in_ready), 64'(2));
    step();
    chk("stall_out_e0", out_data, 64'hE0);
    chk("stall_out_e0_sel", 64'(out_sel), 64'(1));
    set_in(1, 1'b0, 1'b0, 1'b0, 64'h0);
    step();

    // Reset mid-packet with two beats buffered
    out_ready = 1'b0;
    set_in(0, 1'b1, 1'b1, 1'b0, 64'hF0);
    set_in(1, 1'b1, 1'b1, 1'b1, 64'h60);
    #1;
    chk("mid_grant0", 64'(in_ready), 64'(1));
    step();
    set_in(0, 1'b1, 1'b0, 1'b0, 64'hF1);
    #1;
    chk("mid_grant1", 64'(in_ready), 64'(1));
    step();
    chk("mid_full_valid", 64'(out_valid), 64'(1));
    chk("mid_full_ready", 64'(in_ready), 64'(0));
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    sb.delete();
    set_in(0, 1'b0, 1'b0, 1'b0, 64'h0);
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_grant", 64'(in_ready), 64'(2));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    step();
    chk("post_rst_out", out_data, 64'h60);
    chk("post_rst_sel", 64'(out_sel), 64'(1));
    set_in(1, 1'b0, 1'b0, 1'b0, 64'h0);
    step();
    chk("post_rst_no_stale", 64'(out_valid), 64'(0));
    step();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
